// File: rtl/phy_lb_pkg.sv
// Shared definitions for the MAC-PHY loopback emulator: FSM encodings,
// counter widths, reset values and a constant-evaluable clog2.
package phy_lb_pkg;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_VEC  = 2'd1,
        T_DATA = 2'd2,
        T_END  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2,
        R_END  = 2'd3
    } rx_state_t;

    // Counter widths sized for the parameter ranges (VEC_LEN/LB_DELAY <= 255, RX_GAP <= 15)
    localparam int VEC_CNT_W = 8;
    localparam int DLY_CNT_W = 8;
    localparam int GAP_CNT_W = 4;

    localparam tx_state_t TX_RST_STATE = T_IDLE;
    localparam rx_state_t RX_RST_STATE = R_IDLE;

    // Smallest n with 2**n >= value; usable in constant expressions
    function automatic int lb_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/phy_lb_sync_fifo.sv
// Synchronous TX->RX byte FIFO. Pointers carry an extra wrap bit so full and
// empty are distinguished; read data is registered (valid the cycle after pop).
// 'clear' is the block-disable clear (also zeroes read data), 'flush' only
// empties the queue. Both take priority over push and pop.
module phy_lb_sync_fifo
    import phy_lb_pkg::*;
#(
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic                             flush,
    input  logic                             push,
    input  logic [DW-1:0]                    push_data,
    input  logic                             pop,
    output logic [DW-1:0]                    pop_data,
    output logic                             full,
    output logic                             empty,
    output logic [lb_clog2(FIFO_DEPTH):0]    level
);

    localparam int AW = lb_clog2(FIFO_DEPTH);

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_reg, wr_ptr_next;
    logic [AW:0]   rd_ptr_reg, rd_ptr_next;
    logic [DW-1:0] rd_data_reg, rd_data_next;
    logic          do_push;
    logic          do_pop;

    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign level    = wr_ptr_reg - rd_ptr_reg;
    assign do_push  = push && !full && !flush && !clear;
    assign do_pop   = pop && !empty && !flush && !clear;
    assign pop_data = rd_data_reg;

    // Pointer and read-data next-state; clear/flush override push/pop
    always_comb begin
        wr_ptr_next  = wr_ptr_reg;
        rd_ptr_next  = rd_ptr_reg;
        rd_data_next = rd_data_reg;
        if (clear || flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            if (do_push) begin
                wr_ptr_next = wr_ptr_reg + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_next = rd_ptr_reg + (AW+1)'(1);
            end
        end
        if (clear) begin
            rd_data_next = '0;
        end else if (do_pop) begin
            rd_data_next = mem[rd_ptr_reg[AW-1:0]];
        end
    end

    // Storage array write port (no reset so it maps onto RAM)
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // Pointer and registered read-data state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            rd_data_reg <= '0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            rd_data_reg <= rd_data_next;
        end
    end

endmodule

// File: rtl/phy_lb_gen2.sv
// MAC-PHY loopback emulator: the TX FSM absorbs TXSTART/TXVECTOR/TXDATA/TXEND,
// buffers data bytes in a FIFO and the RX FSM replays them as RXSTART/RXDATA/
// RXEND after LB_DELAY cycles, spacing beats by RX_GAP idle cycles. CCA reset
// aborts any frame in flight; macphy_en low holds the block cleared.
module phy_lb_gen2
    import phy_lb_pkg::*;
#(
    parameter int DW         = 8,
    parameter int VEC_LEN    = 31,
    parameter int FIFO_DEPTH = 16,
    parameter int LB_DELAY   = 4,
    parameter int RX_GAP     = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          macphy_en,
    input  logic                          mac2phy_in_txstart_req,
    input  logic                          mac2phy_in_txdata_req,
    input  logic                          mac2phy_in_txend_req,
    input  logic                          mac2phy_in_txdata_val,
    input  logic [DW-1:0]                 mac2phy_in_txdata_frame,
    input  logic                          mac2phy_in_ccareset_req,
    output logic                          phy2mac_out_txstart_confirm,
    output logic                          phy2mac_out_txdata_confirm,
    output logic                          phy2mac_out_txend_confirm,
    output logic                          phy2mac_out_ccareset_confirm,
    output logic                          phy2mac_out_rxstart_ind,
    output logic                          phy2mac_out_rxdata_ind,
    output logic                          phy2mac_out_rxdata_val,
    output logic [DW-1:0]                 phy2mac_out_rxdata,
    output logic                          phy2mac_out_rxend_ind,
    output logic                          lb_busy,
    output logic [lb_clog2(FIFO_DEPTH):0] lb_fifo_level
);

    localparam logic [VEC_CNT_W-1:0] VEC_LAST = VEC_CNT_W'(VEC_LEN - 1);
    localparam logic [DLY_CNT_W-1:0] DLY_INIT = DLY_CNT_W'(LB_DELAY);
    localparam logic [GAP_CNT_W-1:0] GAP_INIT = GAP_CNT_W'(RX_GAP);

    tx_state_t              tx_state_reg, tx_state_next;
    rx_state_t              rx_state_reg, rx_state_next;
    logic [VEC_CNT_W-1:0]   vec_cnt_reg, vec_cnt_next;
    logic [DLY_CNT_W-1:0]   dly_cnt_reg, dly_cnt_next;
    logic [GAP_CNT_W-1:0]   gap_cnt_reg, gap_cnt_next;
    logic                   end_flag_reg, end_flag_next;
    logic                   txstart_cf_reg, txstart_cf_next;
    logic                   txdata_cf_reg, txdata_cf_next;
    logic                   txend_cf_reg, txend_cf_next;
    logic                   cca_cf_reg, cca_cf_next;
    logic                   rxstart_reg, rxstart_next;
    logic                   rxdata_ind_reg, rxdata_ind_next;
    logic                   rxend_reg, rxend_next;

    logic                   cca_hit;
    logic                   busy;
    logic                   tx_accept;
    logic                   end_set;
    logic                   end_clr;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_flush;
    logic                   fifo_clear;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DW-1:0]          fifo_rdata;
    logic [lb_clog2(FIFO_DEPTH):0] fifo_level;

    assign cca_hit    = macphy_en && mac2phy_in_ccareset_req;
    assign busy       = (tx_state_reg != T_IDLE) || (rx_state_reg != R_IDLE);
    assign fifo_clear = !macphy_en;

    phy_lb_sync_fifo #(
        .DW         (DW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (fifo_clear),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (mac2phy_in_txdata_frame),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // TX FSM: vector counting, data acceptance into the FIFO, end handshake
    always_comb begin
        tx_state_next   = tx_state_reg;
        vec_cnt_next    = vec_cnt_reg;
        txstart_cf_next = 1'b0;
        txdata_cf_next  = 1'b0;
        txend_cf_next   = 1'b0;
        tx_accept       = 1'b0;
        fifo_push       = 1'b0;
        end_set         = 1'b0;
        case (tx_state_reg)
            T_IDLE: begin
                if (mac2phy_in_txstart_req && !busy) begin
                    tx_state_next = T_VEC;
                    vec_cnt_next  = '0;
                end
            end
            T_VEC: begin
                // vector content is not stored; only beats are counted
                if (mac2phy_in_txdata_val) begin
                    if (vec_cnt_reg == VEC_LAST) begin
                        txstart_cf_next = 1'b1;
                        tx_state_next   = T_DATA;
                    end else begin
                        vec_cnt_next = vec_cnt_reg + VEC_CNT_W'(1);
                    end
                end
            end
            T_DATA: begin
                // a confirm cycle blocks acceptance, giving one beat per two cycles
                tx_accept = mac2phy_in_txdata_req && mac2phy_in_txdata_val &&
                            !fifo_full && !txdata_cf_reg;
                fifo_push      = tx_accept;
                txdata_cf_next = tx_accept;
                if (mac2phy_in_txend_req) begin
                    tx_state_next = T_END;
                    txend_cf_next = 1'b1;
                end
            end
            T_END: begin
                end_set       = 1'b1;
                tx_state_next = T_IDLE;
            end
            default: tx_state_next = T_IDLE;
        endcase
        // CCA reset aborts the frame; a coincident start request is dropped
        if (cca_hit) begin
            tx_state_next   = T_IDLE;
            txstart_cf_next = 1'b0;
            txdata_cf_next  = 1'b0;
            txend_cf_next   = 1'b0;
            fifo_push       = 1'b0;
            end_set         = 1'b0;
        end
        if (!macphy_en) begin
            tx_state_next   = T_IDLE;
            vec_cnt_next    = '0;
            txstart_cf_next = 1'b0;
            txdata_cf_next  = 1'b0;
            txend_cf_next   = 1'b0;
            fifo_push       = 1'b0;
            end_set         = 1'b0;
        end
    end

    // RX FSM: turnaround delay, paced FIFO replay, end indication
    always_comb begin
        rx_state_next   = rx_state_reg;
        dly_cnt_next    = dly_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        rxstart_next    = 1'b0;
        rxdata_ind_next = 1'b0;
        rxend_next      = 1'b0;
        fifo_pop        = 1'b0;
        fifo_flush      = 1'b0;
        end_clr         = 1'b0;
        case (rx_state_reg)
            R_IDLE: begin
                // launched in step with the txstart_confirm pulse
                if (txstart_cf_next) begin
                    rx_state_next = R_WAIT;
                    dly_cnt_next  = DLY_INIT;
                end
            end
            R_WAIT: begin
                if (dly_cnt_reg == '0) begin
                    rxstart_next  = 1'b1;
                    rx_state_next = R_DATA;
                    gap_cnt_next  = '0;
                end else begin
                    dly_cnt_next = dly_cnt_reg - DLY_CNT_W'(1);
                end
            end
            R_DATA: begin
                if (gap_cnt_reg != '0) begin
                    gap_cnt_next = gap_cnt_reg - GAP_CNT_W'(1);
                end
                if (!fifo_empty) begin
                    if (gap_cnt_reg == '0) begin
                        fifo_pop        = 1'b1;
                        rxdata_ind_next = 1'b1;
                        gap_cnt_next    = GAP_INIT;
                    end
                end else if (end_flag_reg) begin
                    rx_state_next = R_END;
                    rxend_next    = 1'b1;
                    end_clr       = 1'b1;
                end
            end
            R_END: begin
                rx_state_next = R_IDLE;
            end
            default: rx_state_next = R_IDLE;
        endcase
        // CCA reset discards the buffered frame silently (no rxend)
        if (cca_hit && (rx_state_reg != R_IDLE)) begin
            rx_state_next   = R_IDLE;
            rxstart_next    = 1'b0;
            rxdata_ind_next = 1'b0;
            rxend_next      = 1'b0;
            fifo_pop        = 1'b0;
            fifo_flush      = 1'b1;
            end_clr         = 1'b1;
        end
        if (!macphy_en) begin
            rx_state_next   = R_IDLE;
            dly_cnt_next    = '0;
            gap_cnt_next    = '0;
            rxstart_next    = 1'b0;
            rxdata_ind_next = 1'b0;
            rxend_next      = 1'b0;
            fifo_pop        = 1'b0;
            fifo_flush      = 1'b0;
        end
    end

    // End-of-frame flag handed from TX to RX, and the CCA confirm
    always_comb begin
        end_flag_next = end_flag_reg;
        if (end_set) begin
            end_flag_next = 1'b1;
        end
        if (end_clr || !macphy_en) begin
            end_flag_next = 1'b0;
        end
        cca_cf_next = cca_hit;
    end

    // State, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_reg   <= TX_RST_STATE;
            rx_state_reg   <= RX_RST_STATE;
            vec_cnt_reg    <= '0;
            dly_cnt_reg    <= '0;
            gap_cnt_reg    <= '0;
            end_flag_reg   <= 1'b0;
            txstart_cf_reg <= 1'b0;
            txdata_cf_reg  <= 1'b0;
            txend_cf_reg   <= 1'b0;
            cca_cf_reg     <= 1'b0;
            rxstart_reg    <= 1'b0;
            rxdata_ind_reg <= 1'b0;
            rxend_reg      <= 1'b0;
        end else begin
            tx_state_reg   <= tx_state_next;
            rx_state_reg   <= rx_state_next;
            vec_cnt_reg    <= vec_cnt_next;
            dly_cnt_reg    <= dly_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            end_flag_reg   <= end_flag_next;
            txstart_cf_reg <= txstart_cf_next;
            txdata_cf_reg  <= txdata_cf_next;
            txend_cf_reg   <= txend_cf_next;
            cca_cf_reg     <= cca_cf_next;
            rxstart_reg    <= rxstart_next;
            rxdata_ind_reg <= rxdata_ind_next;
            rxend_reg      <= rxend_next;
        end
    end

    assign phy2mac_out_txstart_confirm  = txstart_cf_reg;
    assign phy2mac_out_txdata_confirm   = txdata_cf_reg;
    assign phy2mac_out_txend_confirm    = txend_cf_reg;
    assign phy2mac_out_ccareset_confirm = cca_cf_reg;
    assign phy2mac_out_rxstart_ind      = rxstart_reg;
    assign phy2mac_out_rxdata_ind       = rxdata_ind_reg;
    assign phy2mac_out_rxdata_val       = rxdata_ind_reg;
    assign phy2mac_out_rxdata           = fifo_rdata;
    assign phy2mac_out_rxend_ind        = rxend_reg;
    assign lb_busy                      = busy;
    assign lb_fifo_level                = fifo_level;

endmodule

// File: tb/tb_phy_lb_gen2.sv
// Directed bench for phy_lb_gen2. Two instances share the MAC-side inputs:
// g_dut[0] uses RX_GAP=0, g_dut[1] uses RX_GAP=15; 'sel' picks the one observed.
module tb_phy_lb_gen2;

    localparam int DW       = 8;
    localparam int LW       = 5;
    localparam int LB_DELAY = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          macphy_en;
    logic          txstart_req;
    logic          txdata_req;
    logic          txend_req;
    logic          txdata_val;
    logic          ccareset_req;
    logic [DW-1:0] txdata_frame;

    logic          txstart_cf [2];
    logic          txdata_cf  [2];
    logic          txend_cf   [2];
    logic          cca_cf     [2];
    logic          rxstart    [2];
    logic          rxdata_ind [2];
    logic          rxdata_val [2];
    logic [DW-1:0] rxdata     [2];
    logic          rxend      [2];
    logic          busy       [2];
    logic [LW-1:0] level      [2];

    int            sel;
    logic          o_txstart_cf, o_txdata_cf, o_txend_cf, o_cca_cf, o_rxstart;
    logic          o_rxdata_ind, o_rxdata_val, o_rxend, o_busy;
    logic [DW-1:0] o_rxdata;
    logic [LW-1:0] o_level;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] rx_q [$];
    logic [DW-1:0] exp_q [$];
    int            rxend_cnt;
    int            beats_at_end;
    int            txdata_cf_cnt;
    int            max_level;
    int            val_err;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            phy_lb_gen2 #(
                .DW         (DW),
                .VEC_LEN    (31),
                .FIFO_DEPTH (16),
                .LB_DELAY   (LB_DELAY),
                .RX_GAP     ((gi == 0) ? 0 : 15)
            ) u_dut (
                .clk                          (clk),
                .rst_n                        (rst_n),
                .macphy_en                    (macphy_en),
                .mac2phy_in_txstart_req       (txstart_req),
                .mac2phy_in_txdata_req        (txdata_req),
                .mac2phy_in_txend_req         (txend_req),
                .mac2phy_in_txdata_val        (txdata_val),
                .mac2phy_in_txdata_frame      (txdata_frame),
                .mac2phy_in_ccareset_req      (ccareset_req),
                .phy2mac_out_txstart_confirm  (txstart_cf[gi]),
                .phy2mac_out_txdata_confirm   (txdata_cf[gi]),
                .phy2mac_out_txend_confirm    (txend_cf[gi]),
                .phy2mac_out_ccareset_confirm (cca_cf[gi]),
                .phy2mac_out_rxstart_ind      (rxstart[gi]),
                .phy2mac_out_rxdata_ind       (rxdata_ind[gi]),
                .phy2mac_out_rxdata_val       (rxdata_val[gi]),
                .phy2mac_out_rxdata           (rxdata[gi]),
                .phy2mac_out_rxend_ind        (rxend[gi]),
                .lb_busy                      (busy[gi]),
                .lb_fifo_level                (level[gi])
            );
        end
    endgenerate

    always_comb begin
        o_txstart_cf = txstart_cf[sel];
        o_txdata_cf  = txdata_cf[sel];
        o_txend_cf   = txend_cf[sel];
        o_cca_cf     = cca_cf[sel];
        o_rxstart    = rxstart[sel];
        o_rxdata_ind = rxdata_ind[sel];
        o_rxdata_val = rxdata_val[sel];
        o_rxdata     = rxdata[sel];
        o_rxend      = rxend[sel];
        o_busy       = busy[sel];
        o_level      = level[sel];
    end

    // RX/confirm monitor on the falling edge
    always @(negedge clk) begin
        if (o_rxdata_ind === 1'b1) rx_q.push_back(o_rxdata);
        if (o_rxdata_ind !== o_rxdata_val) val_err++;
        if (o_rxend === 1'b1) begin
            rxend_cnt++;
            beats_at_end = rx_q.size();
        end
        if (o_txdata_cf === 1'b1) txdata_cf_cnt++;
        if (int'(o_level) > max_level) max_level = int'(o_level);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [21:0] all_out();
        return {o_txstart_cf, o_txdata_cf, o_txend_cf, o_cca_cf, o_rxstart,
                o_rxdata_ind, o_rxdata_val, o_rxend, o_busy, o_rxdata, o_level};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int which);
        rst_n        = 1'b0;
        sel          = which;
        macphy_en    = 1'b1;
        txstart_req  = 1'b0;
        txdata_req   = 1'b0;
        txend_req    = 1'b0;
        txdata_val   = 1'b0;
        ccareset_req = 1'b0;
        txdata_frame = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        rx_q.delete();
        rxend_cnt     = 0;
        beats_at_end  = 0;
        txdata_cf_cnt = 0;
        max_level     = 0;
        val_err       = 0;
    endtask

    task automatic send_vector();
        int bad_early = 0;
        int bad_wait  = 0;
        txstart_req = 1'b1;
        tick();
        txstart_req = 1'b0;
        for (int i = 0; i < 31; i++) begin
            txdata_val   = 1'b1;
            txdata_frame = 8'h4E + 8'(i);
            tick();
            if (i < 30 && o_txstart_cf !== 1'b0) bad_early++;
        end
        txdata_val = 1'b0;
        checks++;
        if (bad_early != 0) begin
            failures++;
            $display("FAIL vec_early_confirm got=%0d want=0", bad_early);
        end
        checks++;
        if (o_txstart_cf !== 1'b1) begin
            failures++;
            $display("FAIL vec_confirm got=%b want=1", o_txstart_cf);
        end
        for (int k = 1; k <= LB_DELAY + 1; k++) begin
            tick();
            if (k == 1 && o_txstart_cf !== 1'b0) bad_wait++;
            if (k <= LB_DELAY && o_rxstart !== 1'b0) bad_wait++;
        end
        checks++;
        if (o_rxstart !== 1'b1) begin
            failures++;
            $display("FAIL rxstart_delay got=%b want=1", o_rxstart);
        end
        checks++;
        if (bad_wait != 0) begin
            failures++;
            $display("FAIL rxstart_early got=%0d want=0", bad_wait);
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, output int waited);
        txdata_req   = 1'b1;
        txdata_val   = 1'b1;
        txdata_frame = d;
        waited       = 0;
        do begin
            tick();
            waited++;
        end while (o_txdata_cf !== 1'b1 && waited < 100);
        checks++;
        if (o_txdata_cf !== 1'b1) begin
            failures++;
            $display("FAIL beat_confirm data=%h got=%b want=1", d, o_txdata_cf);
        end
    endtask

    task automatic send_end();
        txdata_req = 1'b0;
        txdata_val = 1'b0;
        txend_req  = 1'b1;
        tick();
        txend_req = 1'b0;
        checks++;
        if (o_txend_cf !== 1'b1) begin
            failures++;
            $display("FAIL txend_confirm got=%b want=1", o_txend_cf);
        end
    endtask

    task automatic wait_rxend(input int limit);
        int c = 0;
        while (rxend_cnt == 0 && c < limit) begin
            tick();
            c++;
        end
        repeat (3) tick();
        checks++;
        if (rxend_cnt != 1) begin
            failures++;
            $display("FAIL rxend_count got=%0d want=1", rxend_cnt);
        end
    endtask

    task automatic check_rx();
        checks++;
        if (rx_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL rx_count got=%0d want=%0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL rx_beat idx=%0d got=%h want=%h", i, rx_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        int w;
        do_reset(0);
        checks++;
        if (all_out() !== 22'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", all_out());
        end
        txend_req = 1'b1;
        tick();
        txend_req = 1'b0;
        checks++;
        if (o_txend_cf !== 1'b0) begin
            failures++;
            $display("FAIL txend_in_idle got=%b want=0", o_txend_cf);
        end
        ccareset_req = 1'b1;
        tick();
        ccareset_req = 1'b0;
        checks++;
        if (o_cca_cf !== 1'b1) begin
            failures++;
            $display("FAIL cca_idle_confirm got=%b want=1", o_cca_cf);
        end
        tick();
        checks++;
        if (o_cca_cf !== 1'b0) begin
            failures++;
            $display("FAIL cca_pulse_width got=%b want=0", o_cca_cf);
        end
        send_vector();
        send_beat(8'h5A, w);
        send_beat(8'hA5, w);
        checks++;
        if (o_busy !== 1'b1 || o_rxdata !== 8'h5A) begin
            failures++;
            $display("FAIL midframe_pre got=%b/%h want=1/5a", o_busy, o_rxdata);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (all_out() !== 22'h0) begin
            failures++;
            $display("FAIL async_reset got=%h want=0", all_out());
        end
        $display("test_reset done");
    endtask

    task automatic test_data();
        int w;
        do_reset(0);
        send_vector();
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(8'h1E + 8'(i));
            send_beat(8'h1E + 8'(i), w);
        end
        send_end();
        wait_rxend(300);
        check_rx();
        checks++;
        if (txdata_cf_cnt != 20) begin
            failures++;
            $display("FAIL data_confirms got=%0d want=20", txdata_cf_cnt);
        end
        checks++;
        if (beats_at_end != 20) begin
            failures++;
            $display("FAIL rxend_after_beats got=%0d want=20", beats_at_end);
        end
        checks++;
        if (o_rxdata !== 8'h31 || o_busy !== 1'b0 || val_err != 0) begin
            failures++;
            $display("FAIL data_tail got=%h/%b/%0d want=31/0/0", o_rxdata, o_busy, val_err);
        end
        $display("test_data rx=%0d", rx_q.size());
    endtask

    task automatic test_backpressure();
        int w;
        int maxw = 0;
        do_reset(1);
        send_vector();
        exp_q.delete();
        for (int i = 0; i < 40; i++) begin
            exp_q.push_back(8'(i * 5 + 7));
            send_beat(8'(i * 5 + 7), w);
            if (w > maxw) maxw = w;
        end
        send_end();
        wait_rxend(1500);
        check_rx();
        checks++;
        if (max_level != 16) begin
            failures++;
            $display("FAIL bp_max_level got=%0d want=16", max_level);
        end
        checks++;
        if (maxw <= 2) begin
            failures++;
            $display("FAIL bp_stall got=%0d want=>2", maxw);
        end
        checks++;
        if (txdata_cf_cnt != 40) begin
            failures++;
            $display("FAIL bp_confirms got=%0d want=40", txdata_cf_cnt);
        end
        $display("test_backpressure rx=%0d max_wait=%0d", rx_q.size(), maxw);
    endtask

    task automatic test_cca();
        int idx = 0;
        int c   = 0;
        int cf_snap;
        do_reset(1);
        send_vector();
        txdata_req   = 1'b1;
        txdata_val   = 1'b1;
        txdata_frame = 8'hA0;
        while (rx_q.size() < 5 && c < 600) begin
            tick();
            c++;
            if (o_txdata_cf === 1'b1) begin
                idx++;
                txdata_frame = 8'hA0 + 8'(idx);
            end
        end
        checks++;
        if (rx_q.size() != 5) begin
            failures++;
            $display("FAIL cca_setup got=%0d want=5", rx_q.size());
        end
        txdata_req   = 1'b0;
        txdata_val   = 1'b0;
        ccareset_req = 1'b1;
        tick();
        ccareset_req = 1'b0;
        checks++;
        if (o_cca_cf !== 1'b1 || o_level !== 5'd0 || o_busy !== 1'b0 || o_txdata_cf !== 1'b0) begin
            failures++;
            $display("FAIL cca_effect got=%b/%0d/%b/%b want=1/0/0/0",
                     o_cca_cf, o_level, o_busy, o_txdata_cf);
        end
        @(negedge clk);
        #1;
        cf_snap = txdata_cf_cnt;
        repeat (40) tick();
        checks++;
        if (rxend_cnt != 0 || rx_q.size() != 5 || txdata_cf_cnt != cf_snap || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL cca_after got=rxend%0d/rx%0d/cf%0d/busy%b want=0/5/%0d/0",
                     rxend_cnt, rx_q.size(), txdata_cf_cnt, o_busy, cf_snap);
        end
        $display("test_cca rx=%0d", rx_q.size());
    endtask

    task automatic test_enable_drop();
        int w;
        do_reset(0);
        send_vector();
        send_beat(8'h11, w);
        send_beat(8'h22, w);
        send_beat(8'h33, w);
        txdata_req  = 1'b0;
        txdata_val  = 1'b0;
        macphy_en   = 1'b0;
        txstart_req = 1'b1;
        tick();
        checks++;
        if (all_out() !== 22'h0) begin
            failures++;
            $display("FAIL en_drop_clear got=%h want=0", all_out());
        end
        tick();
        txstart_req = 1'b0;
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("FAIL en_drop_start_ignored got=%b want=0", o_busy);
        end
        macphy_en = 1'b1;
        tick();
        send_vector();
        checks++;
        if (o_busy !== 1'b1) begin
            failures++;
            $display("FAIL en_restart_busy got=%b want=1", o_busy);
        end
        $display("test_enable_drop done");
    endtask

    initial begin
        sel          = 0;
        rst_n        = 1'b0;
        macphy_en    = 1'b0;
        txstart_req  = 1'b0;
        txdata_req   = 1'b0;
        txend_req    = 1'b0;
        txdata_val   = 1'b0;
        ccareset_req = 1'b0;
        txdata_frame = '0;
        test_reset();
        test_data();
        test_backpressure();
        test_cca();
        test_enable_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
